// File: rtl/uart_pic_ctrl.sv
// UART picture receiver: 0x55 0xAA header, then IMG_W*IMG_H RGB565 pixels (high byte first)
// written to a frame buffer. Define UART_PIC_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_pic_ctrl #(
    parameter int unsigned IMG_W       = 160,
    parameter int unsigned IMG_H       = 120,
    parameter int unsigned ADDR_W      = 15,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]        SYNC_A   = 8'h55;
    localparam logic [7:0]        SYNC_B   = 8'hAA;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPixHi,
        StPixLo,
        StChk
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pix_q, pix_d;
    logic [7:0]          hi_q, hi_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;
    logic                timeout_hit;
`ifdef UART_PIC_CHECKSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    // Timeout wins over a byte arriving on the same cycle.
    assign timeout_hit = (state_q != StIdle) && (tmo_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        hi_d         = hi_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        tmo_d        = (state_q == StIdle || rx_valid) ? '0 : tmo_q + TMO_W'(1);
`ifdef UART_PIC_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        if (timeout_hit) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                StIdle: begin
                    if (rx_data == SYNC_A) state_d = StSync;
                end
                StSync: begin
                    if (rx_data == SYNC_B) begin
                        state_d   = StPixHi;
                        pix_d     = '0;
                        wr_addr_d = '0;
`ifdef UART_PIC_CHECKSUM_EN
                        csum_d    = '0;
`endif
                    end else if (rx_data != SYNC_A) begin
                        state_d = StIdle;
                    end
                end
                StPixHi: begin
                    hi_d    = rx_data;
                    state_d = StPixLo;
`ifdef UART_PIC_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                end
                StPixLo: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_q;
                    wr_data_d = {hi_q, rx_data};
`ifdef UART_PIC_CHECKSUM_EN
                    csum_d    = csum_q ^ rx_data;
`endif
                    if (pix_q == LAST_PIX) begin
                        pix_d = '0;
`ifdef UART_PIC_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d      = StIdle;
                        frame_done_d = 1'b1;
`endif
                    end else begin
                        pix_d   = pix_q + ADDR_W'(1);
                        state_d = StPixHi;
                    end
                end
                StChk: begin
`ifdef UART_PIC_CHECKSUM_EN
                    if (rx_data == csum_q) frame_done_d = 1'b1;
                    else                   err_d        = 1'b1;
`endif
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            pix_q        <= '0;
            hi_q         <= '0;
            tmo_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef UART_PIC_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            hi_q         <= hi_d;
            tmo_q        <= tmo_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
`ifdef UART_PIC_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign busy       = (state_q != StIdle);

endmodule
